// File: rtl/ifu_fetch_if.sv
// Instruction-fetch read channel between the IFU (master) and the instruction SRAM (slave).
// AR and R each use valid/ready: a beat transfers on the rising CLK edge where both are 1; the sender holds valid and payload stable until then.
interface ifu_fetch_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] IFU_AXI4_ARADDR;
    logic                  IFU_AXI4_ARVALID;
    logic                  IFU_AXI4_ARREADY;
    logic [DATA_WIDTH-1:0] IFU_AXI4_RDATA;
    logic                  IFU_AXI4_RVALID;
    logic                  IFU_AXI4_RREADY;

    modport master (
        output IFU_AXI4_ARADDR,
        output IFU_AXI4_ARVALID,
        input  IFU_AXI4_ARREADY,
        input  IFU_AXI4_RDATA,
        input  IFU_AXI4_RVALID,
        output IFU_AXI4_RREADY
    );

    modport slave (
        input  IFU_AXI4_ARADDR,
        input  IFU_AXI4_ARVALID,
        output IFU_AXI4_ARREADY,
        output IFU_AXI4_RDATA,
        output IFU_AXI4_RVALID,
        input  IFU_AXI4_RREADY
    );
endinterface

// File: rtl/ifu_fetch.sv
// Single-outstanding instruction fetch unit: AR -> R -> OUT per instruction, with redirects
// that never abandon an AXI handshake (in-flight data is discarded instead).
module ifu_fetch #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(32'h8000_0000)
) (
    input  logic                  CLK,
    input  logic                  rstn,
    ifu_fetch_if.master           axi,
    output logic                  inst_valid,
    output logic [DATA_WIDTH-1:0] inst,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    input  logic                  inst_ready,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [1:0]            state_dbg
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(4);

    state_t                state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] inst_q;
    logic [ADDR_WIDTH-1:0] inst_pc_q;
    logic                  flush_pend;
    logic [ADDR_WIDTH-1:0] redir_pc;
    logic                  ar_valid_q;
    logic                  r_ready_q;
    logic                  inst_valid_q;

    // Handshake outputs are flops written alongside the state, so no input reaches them combinationally.
    always_ff @(posedge CLK) begin
        if (!rstn) begin
            state        <= S_IDLE;
            pc           <= RESET_PC & ALIGN_MASK;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            flush_pend   <= 1'b0;
            redir_pc     <= '0;
            ar_valid_q   <= 1'b0;
            r_ready_q    <= 1'b0;
            inst_valid_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (redirect_valid) pc <= redirect_pc & ALIGN_MASK;
                    state      <= S_AR;
                    ar_valid_q <= 1'b1;
                end

                S_AR: begin
                    // ARADDR is the PC, so a redirect here is parked rather than applied.
                    if (redirect_valid) begin
                        flush_pend <= 1'b1;
                        redir_pc   <= redirect_pc & ALIGN_MASK;
                    end
                    if (axi.IFU_AXI4_ARREADY) begin
                        state      <= S_R;
                        ar_valid_q <= 1'b0;
                        r_ready_q  <= 1'b1;
                    end
                end

                S_R: begin
                    if (redirect_valid) begin
                        flush_pend <= 1'b1;
                        redir_pc   <= redirect_pc & ALIGN_MASK;
                    end
                    if (axi.IFU_AXI4_RVALID) begin
                        r_ready_q <= 1'b0;
                        if (redirect_valid) begin
                            pc         <= redirect_pc & ALIGN_MASK;
                            flush_pend <= 1'b0;
                            state      <= S_AR;
                            ar_valid_q <= 1'b1;
                        end else if (flush_pend) begin
                            pc         <= redir_pc;
                            flush_pend <= 1'b0;
                            state      <= S_AR;
                            ar_valid_q <= 1'b1;
                        end else begin
                            inst_q       <= axi.IFU_AXI4_RDATA;
                            inst_pc_q    <= pc;
                            state        <= S_OUT;
                            inst_valid_q <= 1'b1;
                        end
                    end
                end

                S_OUT: begin
                    // Redirect wins over inst_ready: the held word is dropped, not delivered.
                    if (redirect_valid) begin
                        pc           <= redirect_pc & ALIGN_MASK;
                        state        <= S_AR;
                        inst_valid_q <= 1'b0;
                        ar_valid_q   <= 1'b1;
                    end else if (inst_ready) begin
                        pc           <= pc + PC_STEP;
                        state        <= S_AR;
                        inst_valid_q <= 1'b0;
                        ar_valid_q   <= 1'b1;
                    end
                end

                default: begin
                    state        <= S_IDLE;
                    ar_valid_q   <= 1'b0;
                    r_ready_q    <= 1'b0;
                    inst_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign axi.IFU_AXI4_ARADDR  = pc;
    assign axi.IFU_AXI4_ARVALID = ar_valid_q;
    assign axi.IFU_AXI4_RREADY  = r_ready_q;
    assign inst_valid           = inst_valid_q;
    assign inst                 = inst_q;
    assign inst_pc              = inst_pc_q;
    assign state_dbg            = state;
endmodule
